// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp
//   Responder side of the PC fetch interface. Takes the fetch address and
//   enable from the PC stage. Fetches the instruction word from a
//   variable-latency instruction memory over a req/ack handshake. Returns
//   the word, tagged with its address, to the IF/ID boundary.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   pc           fetch address from the PC stage
//   ce           fetch enable from the PC stage
//   flush        branch redirect; abandon the current fetch
//   stall_req    combinational hold for the PC stage (its pc_stall)
//   mem_req      instruction-memory request (registered)
//   mem_addr     instruction-memory address (registered)
//   mem_ack      memory response valid, one-cycle pulse
//   mem_rdata    memory read data, valid with mem_ack
//   inst         fetched instruction (registered, held between pulses)
//   inst_pc      address of inst (registered, held between pulses)
//   inst_valid   one-cycle pulse marking inst / inst_pc valid
//   misalign_err one-cycle pulse with inst_valid for a misaligned pc
module inst_fetch_resp #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ce,
  input  logic              flush,
  output logic              stall_req,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              misalign_err
);

  // WAIT: request outstanding, data wanted.
  // DISCARD: request outstanding, data will be dropped. A request that
  // has been issued is never withdrawn, so the ack must still be consumed.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic misaligned;
  logic do_issue;    // launch a memory request for pc
  logic do_capture;  // deliver mem_rdata as a valid instruction
  logic do_misal;    // report a misaligned fetch without touching memory
  logic do_release;  // ack consumed, drop mem_req

  assign misaligned = (pc[1:0] != 2'b00);

  // Next-state and per-cycle actions
  always_comb begin
    state_nxt  = state;
    do_issue   = 1'b0;
    do_capture = 1'b0;
    do_misal   = 1'b0;
    do_release = 1'b0;
    case (state)
      IDLE: begin
        // A stray mem_ack here (e.g. left over from before a reset) is ignored.
        if (ce && !flush) begin
          if (misaligned) begin
            do_misal = 1'b1;
          end else begin
            do_issue  = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          do_release = 1'b1;
          state_nxt  = IDLE;
          // Redirect or disable in the ack cycle makes the data stale.
          if (ce && !flush) begin
            do_capture = 1'b1;
          end
        end else if (flush || !ce) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          do_release = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // PC-stage hold. Misaligned pcs are reported without a memory access, so
  // the PC must not hold on them. In the WAIT ack cycle the PC advances so
  // the next address is ready when inst_valid pulses. flush always releases
  // the PC so it can load the branch target.
  always_comb begin
    stall_req = ce & ~flush;
    if (state == IDLE && misaligned) begin
      stall_req = 1'b0;
    end
    if (state == WAIT && mem_ack) begin
      stall_req = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory request side
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (do_issue) begin
        mem_req  <= 1'b1;
        mem_addr <= pc;
      end else if (do_release) begin
        mem_req  <= 1'b0;
      end
    end
  end

  // IF/ID result side
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst         <= '0;
      inst_pc      <= '0;
      inst_valid   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      inst_valid   <= do_capture | do_misal;
      misalign_err <= do_misal;
      if (do_capture) begin
        inst    <= mem_rdata;
        inst_pc <= mem_addr;
      end else if (do_misal) begin
        inst    <= NOP_INST;
        inst_pc <= pc;
      end
    end
  end

endmodule
